// File: rtl/receive_ethernet_packet_ex_if.sv
// Signal bundle between the user receive side, the RX packet side and
// the receive front end; slave is the front end, master drives it.
interface receive_ethernet_packet_ex_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int COUNT_WIDTH = 11
);
  logic                   ethernet_rcv_req_in;
  logic [DATA_WIDTH-1:0]  ethernet_rcv_data_out;
  logic                   ethernet_rcv_data_rdy_out;
  logic                   ethernet_rcv_complete_out;
  logic [COUNT_WIDTH-1:0] ethernet_rcv_word_count_out;
  logic                   ethernet_rcv_overflow_out;
  logic                   ethernet_rcv_runt_out;
  logic                   ethernet_rcv_dropped_out;
  logic [47:0]            my_mac_in;
  logic                   rx_req_out;
  logic [DATA_WIDTH-1:0]  rx_packet_data_in;
  logic                   rx_packet_data_rdy_in;
  logic                   rx_packet_complete_in;

  modport slave (
    input  ethernet_rcv_req_in,
    output ethernet_rcv_data_out,
    output ethernet_rcv_data_rdy_out,
    output ethernet_rcv_complete_out,
    output ethernet_rcv_word_count_out,
    output ethernet_rcv_overflow_out,
    output ethernet_rcv_runt_out,
    output ethernet_rcv_dropped_out,
    input  my_mac_in,
    output rx_req_out,
    input  rx_packet_data_in,
    input  rx_packet_data_rdy_in,
    input  rx_packet_complete_in
  );

  modport master (
    output ethernet_rcv_req_in,
    input  ethernet_rcv_data_out,
    input  ethernet_rcv_data_rdy_out,
    input  ethernet_rcv_complete_out,
    input  ethernet_rcv_word_count_out,
    input  ethernet_rcv_overflow_out,
    input  ethernet_rcv_runt_out,
    input  ethernet_rcv_dropped_out,
    output my_mac_in,
    input  rx_req_out,
    output rx_packet_data_in,
    output rx_packet_data_rdy_in,
    output rx_packet_complete_in
  );
endinterface

// File: rtl/receive_ethernet_packet_ex.sv
// Receive front end: strips header words, forwards and counts payload.
// Define RX_MAC_FILTER_EN to compile in the destination-MAC filter.
module receive_ethernet_packet_ex #(
  parameter int DATA_WIDTH        = 16,
  parameter int HEADER_WORDS      = 18,
  parameter int MAX_PAYLOAD_WORDS = 1024,
  parameter int COUNT_WIDTH       = 11
) (
  input  logic                          Clock,
  input  logic                          Reset,
  receive_ethernet_packet_ex_if.slave   bus
);
  localparam int HW = $clog2(HEADER_WORDS + 1);

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    PAYLOAD,
    DRAIN,
    DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [HW-1:0]          hdr_q, hdr_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;
  logic                   runt_q, runt_d;
  logic                   drop_q, drop_d;
  logic                   fwd;
  logic                   hdr_last;
  logic                   cnt_full;
  logic                   mac_ok;
  logic                   rdy;
  logic                   cmpl;

`ifdef RX_MAC_FILTER_EN
  localparam int MAC_WORDS = 48 / DATA_WIDTH;
  logic [47:0] mac_q, mac_d;
  logic [47:0] word_ext;

  always_comb begin
    word_ext = 48'(bus.rx_packet_data_in);
    mac_d    = mac_q;
    if (state_q == HEADER && rdy && hdr_q < HW'(MAC_WORDS))
      mac_d = (mac_q << DATA_WIDTH) | word_ext;
    // mac_d already holds the final word when the header is only the MAC
    mac_ok = (mac_d == bus.my_mac_in) || (mac_d == 48'hFFFF_FFFF_FFFF);
  end

  always_ff @(posedge Clock) begin
    if (Reset) mac_q <= '0;
    else       mac_q <= mac_d;
  end
`else
  assign mac_ok = 1'b1;
`endif

  assign rdy      = bus.rx_packet_data_rdy_in;
  assign cmpl     = bus.rx_packet_complete_in;
  assign hdr_last = (hdr_q == HW'(HEADER_WORDS - 1));
  assign cnt_full = (cnt_q == COUNT_WIDTH'(MAX_PAYLOAD_WORDS));

  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    runt_d  = runt_q;
    drop_d  = drop_q;
    fwd     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.ethernet_rcv_req_in) begin
          state_d = HEADER;
          hdr_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          runt_d  = 1'b0;
          drop_d  = 1'b0;
        end
      end
      HEADER: begin
        if (rdy) hdr_d = hdr_q + 1'b1;
        if (rdy && hdr_last) begin
          drop_d = !mac_ok;
          if (cmpl)        state_d = DONE;
          else if (mac_ok) state_d = PAYLOAD;
          else             state_d = DRAIN;
        end else if (cmpl) begin
          runt_d  = 1'b1;
          state_d = DONE;
        end
      end
      PAYLOAD: begin
        if (rdy) begin
          if (cnt_full) begin
            ovf_d   = 1'b1;
            state_d = DRAIN;
          end else begin
            fwd   = 1'b1;
            cnt_d = cnt_q + 1'b1;
          end
        end
        if (cmpl) state_d = DONE;
      end
      DRAIN: begin
        if (cmpl) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      hdr_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      runt_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      runt_q  <= runt_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.ethernet_rcv_data_rdy_out   = fwd;
  assign bus.ethernet_rcv_data_out       = fwd ? bus.rx_packet_data_in
                                               : '0;
  assign bus.ethernet_rcv_complete_out   = (state_q == DONE);
  assign bus.ethernet_rcv_word_count_out = cnt_q;
  assign bus.ethernet_rcv_overflow_out   = ovf_q;
  assign bus.ethernet_rcv_runt_out       = runt_q;
  assign bus.ethernet_rcv_dropped_out    = drop_q;
  assign bus.rx_req_out = (state_q == HEADER) ||
                          (state_q == PAYLOAD) ||
                          (state_q == DRAIN);
endmodule

// File: tb/tb_receive_ethernet_packet_ex.sv
// Directed bench for receive_ethernet_packet_ex with a four-word
// payload limit; MAC-filter cases follow RX_MAC_FILTER_EN.
module tb_receive_ethernet_packet_ex;
  localparam int DW = 16;
  localparam int HW = 18;
  localparam int MX = 4;
  localparam int CW = 11;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  receive_ethernet_packet_ex_if #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) bus ();

  receive_ethernet_packet_ex #(
    .DATA_WIDTH       (DW),
    .HEADER_WORDS     (HW),
    .MAX_PAYLOAD_WORDS(MX),
    .COUNT_WIDTH      (CW)
  ) dut (
    .Clock(clk),
    .Reset(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [47:0] obs,
                     input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one clock: drive inputs, check combinational outputs, then clock
  task automatic cyc(input string tag, input logic req, input logic rdy,
                     input logic cmpl, input logic [DW-1:0] d,
                     input logic e_rdy, input logic [DW-1:0] e_d,
                     input logic e_req, input logic e_cmp);
    bus.ethernet_rcv_req_in   = req;
    bus.rx_packet_data_rdy_in = rdy;
    bus.rx_packet_complete_in = cmpl;
    bus.rx_packet_data_in     = d;
    #3;
    chk({tag, ".rdy"}, 48'(bus.ethernet_rcv_data_rdy_out), 48'(e_rdy));
    chk({tag, ".data"}, 48'(bus.ethernet_rcv_data_out), 48'(e_d));
    chk({tag, ".rxreq"}, 48'(bus.rx_req_out), 48'(e_req));
    chk({tag, ".cmp"}, 48'(bus.ethernet_rcv_complete_out), 48'(e_cmp));
    @(posedge clk);
    #1;
  endtask

  task automatic status(input string tag, input int cnt, input logic ovf,
                        input logic runt, input logic drop);
    chk({tag, ".count"}, 48'(bus.ethernet_rcv_word_count_out), 48'(cnt));
    chk({tag, ".ovf"}, 48'(bus.ethernet_rcv_overflow_out), 48'(ovf));
    chk({tag, ".runt"}, 48'(bus.ethernet_rcv_runt_out), 48'(runt));
    chk({tag, ".drop"}, 48'(bus.ethernet_rcv_dropped_out), 48'(drop));
  endtask

  task automatic header(input string tag, input int n, input logic [47:0] mac,
                        input logic last_cmpl);
    logic [DW-1:0] w;
    for (int i = 0; i < n; i++) begin
      w = (i < 3) ? mac[47-16*i -: 16] : DW'(16'h5A00 + i);
      cyc(tag, 1'b0, 1'b1, last_cmpl && (i == n - 1), w,
          1'b0, '0, 1'b1, 1'b0);
    end
  endtask

  task automatic start(input string tag);
    cyc(tag, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic done(input string tag);
    cyc(tag, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
  endtask

  localparam logic [47:0] MAC = 48'h0011_2233_4455;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.ethernet_rcv_req_in   = 1'b0;
    bus.rx_packet_data_rdy_in = 1'b0;
    bus.rx_packet_complete_in = 1'b0;
    bus.rx_packet_data_in     = '0;
    bus.my_mac_in             = MAC;
    @(posedge clk);
    @(posedge clk);
    #1;
    cyc("rst", 1'b0, 1'b1, 1'b0, 16'hFFFF, 1'b0, '0, 1'b0, 1'b0);
    status("rst", 0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // normal packet: four payload words
    start("p1.req");
    header("p1.hdr", HW, MAC, 1'b0);
    for (int i = 0; i < 4; i++)
      cyc("p1.pay", 1'b0, 1'b1, 1'b0, DW'(16'hA1 + i),
          1'b1, DW'(16'hA1 + i), 1'b1, 1'b0);
    cyc("p1.end", 1'b0, 1'b0, 1'b1, 16'h1234, 1'b0, '0, 1'b1, 1'b0);
    done("p1.done");
    status("p1", 4, 1'b0, 1'b0, 1'b0);
    cyc("p1.idle", 1'b0, 1'b1, 1'b1, 16'h7777, 1'b0, '0, 1'b0, 1'b0);
    status("p1.hold", 4, 1'b0, 1'b0, 1'b0);

    // overflow: six words offered, four forwarded
    start("p2.req");
    header("p2.hdr", HW, MAC, 1'b0);
    for (int i = 0; i < 4; i++)
      cyc("p2.pay", 1'b0, 1'b1, 1'b0, DW'(16'hB1 + i),
          1'b1, DW'(16'hB1 + i), 1'b1, 1'b0);
    cyc("p2.ovf5", 1'b0, 1'b1, 1'b0, 16'hB5, 1'b0, '0, 1'b1, 1'b0);
    cyc("p2.ovf6", 1'b0, 1'b1, 1'b0, 16'hB6, 1'b0, '0, 1'b1, 1'b0);
    cyc("p2.drain", 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    cyc("p2.end", 1'b0, 1'b0, 1'b1, '0, 1'b0, '0, 1'b1, 1'b0);
    done("p2.done");
    status("p2", 4, 1'b1, 1'b0, 1'b0);

    // runt: complete after ten header words
    start("p3.req");
    header("p3.hdr", 10, MAC, 1'b0);
    cyc("p3.end", 1'b0, 1'b0, 1'b1, '0, 1'b0, '0, 1'b1, 1'b0);
    done("p3.done");
    status("p3", 0, 1'b0, 1'b1, 1'b0);
    cyc("p3.idle", 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);

    // last payload word shares the cycle with complete
    start("p4.req");
    header("p4.hdr", HW, MAC, 1'b0);
    cyc("p4.w1", 1'b0, 1'b1, 1'b0, 16'hC1, 1'b1, 16'hC1, 1'b1, 1'b0);
    cyc("p4.w2", 1'b0, 1'b1, 1'b0, 16'hC2, 1'b1, 16'hC2, 1'b1, 1'b0);
    cyc("p4.w3", 1'b0, 1'b1, 1'b1, 16'hC3, 1'b1, 16'hC3, 1'b1, 1'b0);
    // request held through DONE is only taken in IDLE
    cyc("p4.done", 1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    status("p4", 3, 1'b0, 1'b0, 1'b0);
    cyc("p5.idle", 1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);

    // complete with the final header word: empty payload, no runt
    header("p5.hdr", HW, MAC, 1'b1);
    done("p5.done");
    status("p5", 0, 1'b0, 1'b0, 1'b0);

    // reset in the middle of the payload
    start("p6.req");
    header("p6.hdr", HW, MAC, 1'b0);
    cyc("p6.w1", 1'b0, 1'b1, 1'b0, 16'hD1, 1'b1, 16'hD1, 1'b1, 1'b0);
    cyc("p6.w2", 1'b0, 1'b1, 1'b0, 16'hD2, 1'b1, 16'hD2, 1'b1, 1'b0);
    rst = 1'b1;
    bus.rx_packet_data_in = 16'hD3;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc("p6.rst", 1'b0, 1'b1, 1'b0, 16'hD4, 1'b0, '0, 1'b0, 1'b0);
    status("p6.rst", 0, 1'b0, 1'b0, 1'b0);
    start("p7.req");
    header("p7.hdr", HW, MAC, 1'b0);
    cyc("p7.w1", 1'b0, 1'b1, 1'b1, 16'hE1, 1'b1, 16'hE1, 1'b1, 1'b0);
    done("p7.done");
    status("p7", 1, 1'b0, 1'b0, 1'b0);
    cyc("p7.idle", 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);

`ifdef RX_MAC_FILTER_EN
    start("m1.req");
    header("m1.hdr", HW, 48'h0011_2233_4455, 1'b0);
    cyc("m1.w1", 1'b0, 1'b1, 1'b1, 16'hF1, 1'b1, 16'hF1, 1'b1, 1'b0);
    done("m1.done");
    status("m1", 1, 1'b0, 1'b0, 1'b0);
    cyc("m2.idle", 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    start("m2.req");
    header("m2.hdr", HW, 48'hFFFF_FFFF_FFFF, 1'b0);
    cyc("m2.w1", 1'b0, 1'b1, 1'b1, 16'hF2, 1'b1, 16'hF2, 1'b1, 1'b0);
    done("m2.done");
    status("m2", 1, 1'b0, 1'b0, 1'b0);
    cyc("m3.idle", 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    start("m3.req");
    header("m3.hdr", HW, 48'h0011_2233_4456, 1'b0);
    cyc("m3.w1", 1'b0, 1'b1, 1'b0, 16'hF3, 1'b0, '0, 1'b1, 1'b0);
    cyc("m3.end", 1'b0, 1'b1, 1'b1, 16'hF4, 1'b0, '0, 1'b1, 1'b0);
    done("m3.done");
    status("m3", 0, 1'b0, 1'b0, 1'b1);
`else
    start("m1.req");
    header("m1.hdr", HW, 48'h0011_2233_4456, 1'b0);
    cyc("m1.w1", 1'b0, 1'b1, 1'b1, 16'hF1, 1'b1, 16'hF1, 1'b1, 1'b0);
    done("m1.done");
    status("m1", 1, 1'b0, 1'b0, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/receive_ethernet_packet_ex.md
Name: receive_ethernet_packet_ex

Overview:
- Parametrised next-generation receive front end that sits between the user receive interface and the RX packet interface.
- On a user request it asserts the RX request and discards a configurable number of header words.
- It then forwards payload words, counts them, and enforces a maximum payload length.
- At the end of each packet it reports a one-cycle completion with status: word count, overflow, runt and (optionally) MAC-filter drop.

Parameters:
- DATA_WIDTH, 16: width of RX and user data words. Must divide 48 (8, 16, 24 or 48).
- HEADER_WORDS, 18: number of leading RX words discarded per packet. Must be ≥ 48/DATA_WIDTH.
- MAX_PAYLOAD_WORDS, 1024: maximum number of payload words forwarded per packet.
- COUNT_WIDTH, 11: width of the payload word counter. Must satisfy 2^COUNT_WIDTH > MAX_PAYLOAD_WORDS.

Ports:
- Clock  input  1  system clock; all logic is on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- ethernet_rcv_req_in  input  1  user request to receive one packet.
- ethernet_rcv_data_out  output  DATA_WIDTH  payload word; zero when not valid.
- ethernet_rcv_data_rdy_out  output  1  payload word valid this cycle.
- ethernet_rcv_complete_out  output  1  one-cycle end-of-packet pulse.
- ethernet_rcv_word_count_out  output  COUNT_WIDTH  number of payload words forwarded; held after completion.
- ethernet_rcv_overflow_out  output  1  payload exceeded MAX_PAYLOAD_WORDS; held.
- ethernet_rcv_runt_out  output  1  packet ended inside the header; held.
- ethernet_rcv_dropped_out  output  1  packet rejected by the MAC filter; held.
- my_mac_in  input  48  station MAC address, used only when the filter is compiled in.
- rx_req_out  output  1  request to the RX interface.
- rx_packet_data_in  input  DATA_WIDTH  RX word.
- rx_packet_data_rdy_in  input  1  RX word valid.
- rx_packet_complete_in  input  1  RX packet finished.

Behaviour:
- States: IDLE, HEADER, PAYLOAD, DRAIN, DONE.
- Reset forces IDLE, clears all counters and flags, and drives every output to 0 (including rx_req_out) on the next edge. Applies mid-packet too.
- rx_req_out = 1 in HEADER, PAYLOAD and DRAIN; 0 in IDLE and DONE.
- IDLE:
  - On ethernet_rcv_req_in = 1: go to HEADER, clear the header counter, word count and the three flags.
  - Otherwise stay in IDLE; status outputs keep the last packet's values.
- HEADER:
  - Each cycle with rx_packet_data_rdy_in increments the header counter. The word is not forwarded.
  - On the cycle the HEADER_WORDS-th word is accepted: go to PAYLOAD (or DRAIN, see filter).
  - rx_packet_complete_in before that word (including the same cycle as an earlier header word): set runt, go to DONE.
  - Complete on the same cycle as the final header word: treat as a zero-length payload, go to DONE with no runt.
- PAYLOAD:
  - ethernet_rcv_data_rdy_out = rx_packet_data_rdy_in and ethernet_rcv_data_out = rx_packet_data_in, combinationally (zero latency).
  - Each forwarded word increments the word count.
  - A word arriving when count == MAX_PAYLOAD_WORDS is not forwarded: set overflow, go to DRAIN.
  - rx_packet_complete_in: go to DONE. A word valid in the same cycle is forwarded and counted first.
- DRAIN:
  - No words are forwarded; data_out = 0 and data_rdy_out = 0.
  - Leave on rx_packet_complete_in, going to DONE.
- DONE:
  - ethernet_rcv_complete_out = 1 for exactly one cycle, then return to IDLE.
  - A request present during DONE is ignored. It is sampled again in IDLE (minimum one idle cycle between packets).
- data_out is 0 in every cycle where data_rdy_out = 0.
- Word count saturates at MAX_PAYLOAD_WORDS and never wraps.
- rx inputs are ignored in IDLE and DONE.

Optional Feature:
- Macro: RX_MAC_FILTER_EN.
- When defined:
  - The first 48/DATA_WIDTH header words are captured, first word into the most-significant bits, forming the destination MAC.
  - When the last header word is accepted, the captured MAC is compared with my_mac_in and with 48'hFFFFFFFFFFFF.
  - On a match with either: go to PAYLOAD.
  - Otherwise: set dropped, go to DRAIN; the packet still ends with a complete pulse and word count 0.
- When undefined: my_mac_in is ignored, dropped stays 0, and all packets are accepted.

Test Plan:
- DATA_WIDTH=16, HEADER_WORDS=18: request, 18 header words, then 4 payload words 16'hA1..A4, then complete → exactly 4 data_rdy pulses with A1..A4, one complete pulse, count=4, all flags 0.
- MAX_PAYLOAD_WORDS=4 with 6 payload words → 4 forwarded, overflow=1, rx_req_out held until complete, count=4.
- Complete after 10 header words → no data_rdy pulses, runt=1, count=0, complete pulse, return to IDLE.
- Payload word and complete in the same cycle after 2 words → third word forwarded, count=3, complete pulse the next cycle.
- Reset asserted mid-PAYLOAD → next cycle rx_req_out=0, all outputs 0, state IDLE; a new request then behaves normally.
- RX_MAC_FILTER_EN, my_mac_in=48'h001122334455: header MAC 0011_2233_4455 → accepted; FFFF_FFFF_FFFF → accepted; 0011_2233_4456 → dropped=1, count=0, complete pulse.
